// File: rtl/add_round_key_16_if.sv
// Bus bundle for add_round_key_16: key load, add-round-key request and result/status.
// The zeroize line only exists when ARK_ZEROIZE_EN is defined.
interface add_round_key_16_if;
  logic        key_load;
  logic [15:0] key_in;
  logic        ark_en;
  logic [3:0]  round_idx;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        out_valid;
  logic        key_ready;
  logic        err;
`ifdef ARK_ZEROIZE_EN
  logic        zeroize;
`endif

  // master: round controller side; slave: the add-round-key stage
  modport master (
    output key_load, key_in, ark_en, round_idx, data_in,
`ifdef ARK_ZEROIZE_EN
    output zeroize,
`endif
    input  data_out, out_valid, key_ready, err
  );

  modport slave (
    input  key_load, key_in, ark_en, round_idx, data_in,
`ifdef ARK_ZEROIZE_EN
    input  zeroize,
`endif
    output data_out, out_valid, key_ready, err
  );
endinterface

// File: rtl/add_round_key_16.sv
// Add-round-key stage with on-chip key schedule: expands a 16-bit master key into NR round keys.
// Optional macro ARK_ZEROIZE_EN adds a synchronous zeroize input that wipes all key material.
module add_round_key_16 #(
  parameter int NR = 2
) (
  input  logic              clk,
  input  logic              rst,
  add_round_key_16_if.slave bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        key_ready_reg;
  logic [15:0] data_out_reg;
  logic        out_valid_reg;
  logic        err_reg;

  logic [15:0] rk_reg [0:NR];

  logic [NR:0]       rk_we;
  logic [NR:0][15:0] rk_wdata;

  logic        zeroize;
  logic        exp_step;
  logic        ark_ok;
  logic [15:0] prev_key;
  logic [15:0] rk_sel;
  logic [15:0] next_key;
  logic [3:0]  w4, w5, w6, w7;

`ifdef ARK_ZEROIZE_EN
  assign zeroize = bus.zeroize;
`else
  assign zeroize = 1'b0;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hD;  4'h3: y = 4'h1;
      4'h4: y = 4'h2;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h8;
      4'h8: y = 4'h3;  4'h9: y = 4'hA;  4'hA: y = 4'h6;  4'hB: y = 4'hC;
      4'hC: y = 4'h5;  4'hD: y = 4'h9;  4'hE: y = 4'h0;  default: y = 4'h7;
    endcase
    return y;
  endfunction

  // Successive powers of x in GF(2^4) mod x^4+x+1
  function automatic logic [3:0] rcon(input logic [3:0] r);
    logic [3:0] c;
    case (r)
      4'd1: c = 4'h1;  4'd2: c = 4'h2;  4'd3: c = 4'h4;  4'd4: c = 4'h8;
      4'd5: c = 4'h3;  4'd6: c = 4'h6;  4'd7: c = 4'hC;  4'd8: c = 4'hB;
      default: c = 4'h0;
    endcase
    return c;
  endfunction

  // Previous round key (index cnt-1) and the key selected by round_idx
  always_comb begin
    prev_key = '0;
    rk_sel   = '0;
    for (int i = 0; i < NR; i++) begin
      if (cnt_reg == 4'(i + 1)) prev_key = rk_reg[i];
    end
    for (int i = 0; i <= NR; i++) begin
      if (bus.round_idx == 4'(i)) rk_sel = rk_reg[i];
    end
  end

  assign w4       = prev_key[15:12] ^ sbox(prev_key[3:0]) ^ rcon(cnt_reg);
  assign w5       = prev_key[11:8] ^ w4;
  assign w6       = prev_key[7:4] ^ w5;
  assign w7       = prev_key[3:0] ^ w6;
  assign next_key = {w4, w5, w6, w7};

  // A key_load during expansion restarts it, so no schedule step is taken that cycle
  assign exp_step = (state_reg == EXPAND) && !bus.key_load && !zeroize;
  assign ark_ok   = key_ready_reg && !bus.key_load && (bus.round_idx <= NR_IDX);

  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_rk_wr
      if (gi == 0) begin : g_master
        assign rk_we[gi]    = bus.key_load;
        assign rk_wdata[gi] = bus.key_in;
      end else begin : g_round
        assign rk_we[gi]    = exp_step && (cnt_reg == 4'(gi));
        assign rk_wdata[gi] = next_key;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) rk_reg[i] <= '0;
    end else if (zeroize) begin
      for (int i = 0; i <= NR; i++) rk_reg[i] <= '0;
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (rk_we[i]) rk_reg[i] <= rk_wdata[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      key_ready_reg <= 1'b0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      if (zeroize) begin
        state_reg     <= IDLE;
        cnt_reg       <= '0;
        key_ready_reg <= 1'b0;
        data_out_reg  <= '0;
      end else begin
        if (bus.ark_en) begin
          if (ark_ok) begin
            data_out_reg  <= bus.data_in ^ rk_sel;
            out_valid_reg <= 1'b1;
          end else begin
            err_reg <= 1'b1;
          end
        end
        case (state_reg)
          IDLE: begin
            key_ready_reg <= 1'b0;
            if (bus.key_load) begin
              cnt_reg   <= 4'd1;
              state_reg <= EXPAND;
            end
          end
          EXPAND: begin
            if (bus.key_load) begin
              cnt_reg <= 4'd1;
            end else if (cnt_reg == NR_IDX) begin
              state_reg     <= READY;
              key_ready_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
          READY: begin
            if (bus.key_load) begin
              key_ready_reg <= 1'b0;
              cnt_reg       <= 4'd1;
              state_reg     <= EXPAND;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out  = data_out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.key_ready = key_ready_reg;
  assign bus.err       = err_reg;

endmodule
